// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Resolves load-use hazards, taken branches/jumps resolved in MEM,
// multi-cycle data-memory accesses and overflow traps. Also keeps a
// saturating stall counter, the EPC register and a sticky memory-error flag.
//
// Ports:
//   clk, regReset            clock, synchronous active-high reset
//   rs_id, rt_id             source registers of the ID instruction
//   use_rs_id, use_rt_id     ID instruction really reads rs / rt
//   memRd_ex, rw_ex          EX instruction is a load / its destination
//   memReq_mem, mem_ack      MEM data access request / completion
//   branch_taken_mem         taken branch or jump resolved in MEM
//   overflow_mem             MEM instruction overflowed
//   instru_memAddress        PC of the MEM instruction
//   *_stall                  hold PC, IF/ID, ID/EX, EX/MEM
//   *_flush                  bubble IF/ID, ID/EX, EX/MEM, MEM/WB
//   trap                     PC loads the exception vector
//   mem_busy                 controller is waiting on data memory
//   mem_err                  sticky: a data access timed out
//   epc                      PC of the last overflowing instruction
//   stall_cnt                saturating count of pc_stall cycles
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             regReset,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             memRd_ex,
  input  logic [4:0]       rw_ex,
  input  logic             memReq_mem,
  input  logic             mem_ack,
  input  logic             branch_taken_mem,
  input  logic             overflow_mem,
  input  logic [31:0]      instru_memAddress,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             trap,
  output logic             mem_busy,
  output logic             mem_err,
  output logic [31:0]      epc,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MEMWAIT = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              epc_load;
  logic              mem_err_set;
  logic              load_use;

  // EX load feeding a register the ID instruction actually reads ($0 never hazards)
  assign load_use = memRd_ex && (rw_ex != 5'd0) &&
                    ((use_rs_id && (rs_id == rw_ex)) ||
                     (use_rt_id && (rt_id == rw_ex)));

  // Next state and combinational pipeline controls
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    epc_load    = 1'b0;
    mem_err_set = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    trap        = 1'b0;
    mem_busy    = 1'b0;

    if (regReset) begin
      // Pipeline registers are cleared through their flush inputs during reset
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_nxt   = RUN;
      wcnt_nxt    = '0;
    end else begin
      case (state)
        RUN: begin
          if (overflow_mem) begin
            trap        = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            epc_load    = 1'b1;
          end else if (branch_taken_mem) begin
            // The branch itself retires, so MEM/WB is left alone
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (memReq_mem && !mem_ack) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
            state_nxt   = MEMWAIT;
            wcnt_nxt    = WCNT_W'(1);
          end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
          end
        end
        MEMWAIT: begin
          mem_busy = 1'b1;
          if (mem_ack) begin
            state_nxt = RUN;
            wcnt_nxt  = '0;
          end else begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
            // Last allowed wait cycle still holds; the access is dropped at its edge
            if (wcnt == WCNT_W'(MEM_TIMEOUT)) begin
              mem_err_set = 1'b1;
              state_nxt   = RUN;
              wcnt_nxt    = '0;
            end else begin
              wcnt_nxt = wcnt + WCNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end
      endcase
    end
  end

  // FSM state and wait counter
  always_ff @(posedge clk) begin
    if (regReset) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // EPC, sticky memory error and saturating stall counter
  always_ff @(posedge clk) begin
    if (regReset) begin
      epc       <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (epc_load) begin
        epc <= instru_memAddress;
      end
      if (mem_err_set) begin
        mem_err <= 1'b1;
      end
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for single-cycle RUN
// decisions plus hand sequences for memory wait, timeout, overflow, reset
// in MEMWAIT and stall-counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned CMX = 7;

  logic        clk;
  logic        regReset;
  logic [4:0]  rs_id, rt_id, rw_ex;
  logic        use_rs_id, use_rt_id, memRd_ex;
  logic        memReq_mem, mem_ack, branch_taken_mem, overflow_mem;
  logic [31:0] instru_memAddress;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        trap, mem_busy, mem_err;
  logic [31:0] epc;
  logic [CW-1:0] stall_cnt;

  logic [3:0] st;
  logic [3:0] fl;
  assign st = {pc_stall, ifid_stall, idex_stall, exmem_stall};
  assign fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .regReset(regReset),
    .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .memRd_ex(memRd_ex), .rw_ex(rw_ex),
    .memReq_mem(memReq_mem), .mem_ack(mem_ack),
    .branch_taken_mem(branch_taken_mem), .overflow_mem(overflow_mem),
    .instru_memAddress(instru_memAddress),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush),
    .trap(trap), .mem_busy(mem_busy), .mem_err(mem_err), .epc(epc),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rs, rt, rw;
    logic        urs, urt, memrd, req, ack, br, ovf;
    logic [31:0] pc;
    logic [3:0]  exp_st;   // {pc, ifid, idex, exmem}
    logic [3:0]  exp_fl;   // {ifid, idex, exmem, memwb}
    logic        exp_trap;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mkv(string name, logic [4:0] rs, logic [4:0] rt, logic [4:0] rw,
                               logic urs, logic urt, logic memrd, logic req, logic ack,
                               logic br, logic ovf, logic [31:0] pc,
                               logic [3:0] es, logic [3:0] ef, logic et);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.rw = rw;
    v.urs = urs; v.urt = urt; v.memrd = memrd; v.req = req; v.ack = ack;
    v.br = br; v.ovf = ovf; v.pc = pc;
    v.exp_st = es; v.exp_fl = ef; v.exp_trap = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs_id = 5'd0; rt_id = 5'd0; rw_ex = 5'd0;
    use_rs_id = 1'b0; use_rt_id = 1'b0; memRd_ex = 1'b0;
    memReq_mem = 1'b0; mem_ack = 1'b0; branch_taken_mem = 1'b0;
    overflow_mem = 1'b0; instru_memAddress = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    rs_id = v.rs; rt_id = v.rt; rw_ex = v.rw;
    use_rs_id = v.urs; use_rt_id = v.urt; memRd_ex = v.memrd;
    memReq_mem = v.req; mem_ack = v.ack; branch_taken_mem = v.br;
    overflow_mem = v.ovf; instru_memAddress = v.pc;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    regReset = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_flush", 64'(fl), 64'hF);
    chk("rst_stall", 64'(st), 64'h0);
    chk("rst_trap_busy", 64'({trap, mem_busy}), 64'h0);
    next_cyc();
    regReset = 1'b0;
    @(negedge clk);
    chk("rst_regs", 64'({mem_busy, mem_err, stall_cnt}), 64'h0);
    chk("rst_epc", 64'(epc), 64'h0);
    next_cyc();
  endtask

  initial begin
    int exp_cnt;
    int stall_seen;
    int busy_stall;

    vecs[0]  = mkv("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        4'b0000, 4'b0000, 0);
    vecs[1]  = mkv("lu_rs",        8, 0, 8, 1, 0, 1, 0, 0, 0, 0, 32'h0,        4'b1100, 4'b0100, 0);
    vecs[2]  = mkv("lu_rw0",       0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0,        4'b0000, 4'b0000, 0);
    vecs[3]  = mkv("lu_rt",        1, 5, 5, 0, 1, 1, 0, 0, 0, 0, 32'h0,        4'b1100, 4'b0100, 0);
    vecs[4]  = mkv("rt_unused",    1, 5, 5, 0, 0, 1, 0, 0, 0, 0, 32'h0,        4'b0000, 4'b0000, 0);
    vecs[5]  = mkv("not_load",     8, 0, 8, 1, 0, 0, 0, 0, 0, 0, 32'h0,        4'b0000, 4'b0000, 0);
    vecs[6]  = mkv("br_over_lu",   8, 0, 8, 1, 0, 1, 0, 0, 1, 0, 32'h0,        4'b0000, 4'b1110, 0);
    vecs[7]  = mkv("zero_wait",    0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0,        4'b0000, 4'b0000, 0);
    vecs[8]  = mkv("zw_plus_lu",   9, 0, 9, 1, 0, 1, 1, 1, 0, 0, 32'h0,        4'b1100, 4'b0100, 0);
    vecs[9]  = mkv("ovf_over_br",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        4'b0000, 4'b1110, 0);
    vecs[9].ovf = 1'b1; vecs[9].pc = 32'h0040_0018;
    vecs[9].exp_fl = 4'b1111; vecs[9].exp_trap = 1'b1;
    vecs[10] = mkv("ovf_over_mem", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0040_0100, 4'b0000, 4'b1111, 1);
    vecs[11] = mkv("br_over_mem",  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0,        4'b0000, 4'b1110, 0);

    idle();
    regReset = 1'b1;
    next_cyc();
    do_reset();

    // Single-cycle decisions in RUN; none of these leave RUN
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_stall"}, 64'(st), 64'(vecs[i].exp_st));
      chk({vecs[i].name, "_flush"}, 64'(fl), 64'(vecs[i].exp_fl));
      chk({vecs[i].name, "_trap_busy"}, 64'({trap, mem_busy}), 64'({vecs[i].exp_trap, 1'b0}));
      chk({vecs[i].name, "_cnt"}, 64'(stall_cnt), 64'(exp_cnt));
      next_cyc();
      if (vecs[i].exp_st[3] && exp_cnt < CMX) exp_cnt++;
    end
    idle();
    @(negedge clk);
    chk("tbl_end_busy", 64'(mem_busy), 64'h0);
    chk("tbl_end_epc", 64'(epc), 64'h0040_0100);
    chk("tbl_end_cnt", 64'(stall_cnt), 64'(exp_cnt));
    next_cyc();

    // Memory access acked on the fourth cycle: three stall cycles
    do_reset();
    stall_seen = 0;
    busy_stall = 0;
    memReq_mem = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mw_stall", 64'(st), 64'hF);
      chk("mw_flush", 64'(fl), 64'h1);
      chk("mw_busy", 64'(mem_busy), 64'(k > 0));
      if (pc_stall) stall_seen++;
      if (pc_stall && mem_busy) busy_stall++;
      next_cyc();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("mw_ack_out", 64'({st, fl}), 64'h0);
    chk("mw_ack_busy", 64'(mem_busy), 64'h1);
    next_cyc();
    idle();
    @(negedge clk);
    chk("mw_after", 64'({mem_busy, mem_err}), 64'h0);
    chk("mw_cnt", 64'(stall_cnt), 64'd3);
    chk("mw_stall_cycles", 64'(stall_seen), 64'd3);
    chk("mw_busy_stalled", 64'(busy_stall), 64'd2);
    next_cyc();

    // Overflow with concurrent branch: one trap cycle, EPC next cycle
    overflow_mem = 1'b1;
    branch_taken_mem = 1'b1;
    instru_memAddress = 32'h0040_0018;
    @(negedge clk);
    chk("ovf_trap", 64'(trap), 64'h1);
    chk("ovf_flush", 64'(fl), 64'hF);
    chk("ovf_stall", 64'(st), 64'h0);
    chk("ovf_epc_before", 64'(epc), 64'h0);
    next_cyc();
    idle();
    @(negedge clk);
    chk("ovf_epc_after", 64'(epc), 64'h0040_0018);
    chk("ovf_done", 64'({trap, fl}), 64'h0);
    next_cyc();

    // Timeout: entry cycle plus TO wait cycles stall, then sticky error
    do_reset();
    memReq_mem = 1'b1;
    for (int k = 0; k <= int'(TO); k++) begin
      @(negedge clk);
      chk("to_stall", 64'(st), 64'hF);
      chk("to_memwb", 64'(memwb_flush), 64'h1);
      chk("to_busy", 64'(mem_busy), 64'(k > 0));
      chk("to_err_early", 64'(mem_err), 64'h0);
      next_cyc();
    end
    memReq_mem = 1'b0;
    @(negedge clk);
    chk("to_run", 64'({mem_busy, st}), 64'h0);
    chk("to_err", 64'(mem_err), 64'h1);
    chk("to_cnt", 64'(stall_cnt), 64'(TO + 1));
    next_cyc();
    repeat (3) next_cyc();
    memReq_mem = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("to_zw_stall", 64'(st), 64'h0);
    next_cyc();
    idle();
    @(negedge clk);
    chk("to_err_sticky", 64'(mem_err), 64'h1);
    chk("to_cnt_hold", 64'(stall_cnt), 64'(TO + 1));
    next_cyc();

    // Reset asserted while waiting on memory
    overflow_mem = 1'b1;
    instru_memAddress = 32'h0040_0040;
    next_cyc();
    idle();
    memReq_mem = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("rmw_busy", 64'(mem_busy), 64'h1);
    chk("rmw_epc", 64'(epc), 64'h0040_0040);
    next_cyc();
    regReset = 1'b1;
    @(negedge clk);
    chk("rmw_rst_flush", 64'(fl), 64'hF);
    chk("rmw_rst_out", 64'({st, trap, mem_busy}), 64'h0);
    next_cyc();
    regReset = 1'b0;
    memReq_mem = 1'b0;
    @(negedge clk);
    chk("rmw_after", 64'({mem_busy, mem_err, stall_cnt}), 64'h0);
    chk("rmw_epc_clr", 64'(epc), 64'h0);
    next_cyc();

    // Stall counter saturates at its maximum
    rs_id = 5'd12; use_rs_id = 1'b1; memRd_ex = 1'b1; rw_ex = 5'd12;
    repeat (CMX + 3) begin
      @(negedge clk);
      chk("sat_stall", 64'(pc_stall), 64'h1);
      next_cyc();
    end
    idle();
    @(negedge clk);
    chk("sat_cnt", 64'(stall_cnt), 64'(CMX));
    next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
